// File: rtl/bip_data_memory_2r1w.sv
// bip_data_memory_2r1w: BIP data memory with one write port and two independent read ports.
// On reset a built-in sequencer zeroes every word before any request is accepted.
// Read ports have registered outputs with a latency of 1 or 2 cycles and a valid pulse each.
// Optional feature macro: BIP_DMEM_WR_BYPASS_EN
//   defined   -> write-first: a same-cycle read of the written address returns i_data
//   undefined -> read-first: such a read returns the previous contents
module bip_data_memory_2r1w #(
  parameter int NB_DATA          = 16,
  parameter int N_ADDR           = 1024,
  parameter int LOG2_N_DATA_ADDR = 10,
  parameter int RD_LATENCY       = 1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_wr,
  input  logic [LOG2_N_DATA_ADDR-1:0] i_addr_w,
  input  logic [NB_DATA-1:0]          i_data,
  input  logic                        i_rd_a,
  input  logic [LOG2_N_DATA_ADDR-1:0] i_addr_a,
  output logic [NB_DATA-1:0]          o_data_a,
  output logic                        o_valid_a,
  input  logic                        i_rd_b,
  input  logic [LOG2_N_DATA_ADDR-1:0] i_addr_b,
  output logic [NB_DATA-1:0]          o_data_b,
  output logic                        o_valid_b,
  output logic                        o_busy
);

  // The array spans the full address space so every address indexes it without
  // truncation; entries at or above N_ADDR are never written nor read.
  localparam int DEPTH = 2 ** LOG2_N_DATA_ADDR;
  localparam logic [LOG2_N_DATA_ADDR-1:0] LAST_ADDR  = LOG2_N_DATA_ADDR'(N_ADDR - 1);
  localparam logic [LOG2_N_DATA_ADDR:0]   N_ADDR_EXT = (LOG2_N_DATA_ADDR + 1)'(N_ADDR);
  localparam logic [LOG2_N_DATA_ADDR-1:0] CNT_ONE    = LOG2_N_DATA_ADDR'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [LOG2_N_DATA_ADDR-1:0] r_clearCnt;
  logic                        w_busy;
  logic                        w_clearWe;

  logic [NB_DATA-1:0] r_mem [DEPTH];

  logic                        w_ready;
  logic                        w_wrAddrOk;
  logic                        w_userWe;
  logic                        w_memWe;
  logic [LOG2_N_DATA_ADDR-1:0] w_memAddr;
  logic [NB_DATA-1:0]          w_memData;

  logic               w_rdReqA;
  logic               w_rdReqB;
  logic               w_rdAddrOkA;
  logic               w_rdAddrOkB;
  logic [NB_DATA-1:0] w_rdWordA;
  logic [NB_DATA-1:0] w_rdWordB;

  logic               r_validA1;
  logic               r_validB1;
  logic [NB_DATA-1:0] r_dataA1;
  logic [NB_DATA-1:0] r_dataB1;

  // State register: reset always restarts the clear sequence from scratch.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and sequencer controls: CLEAR writes one zero word per cycle and
  // hands over to READY on the same edge that writes the last word.
  always_comb begin
    w_stateNext = r_state;
    w_busy      = 1'b0;
    w_clearWe   = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        w_busy    = 1'b1;
        w_clearWe = 1'b1;
        if (r_clearCnt == LAST_ADDR) begin
          w_stateNext = ST_READY;
        end
      end
      ST_READY: begin
        w_stateNext = ST_READY;
      end
      default: begin
        w_stateNext = ST_CLEAR;
        w_busy      = 1'b1;
      end
    endcase
  end

  assign o_busy = w_busy;

  // Clear address counter: zeroed on reset, advances once per clear write.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_clearCnt <= '0;
    end else if (w_clearWe) begin
      r_clearCnt <= r_clearCnt + CNT_ONE;
    end
  end

  assign w_ready    = (r_state == ST_READY) && !i_reset;
  assign w_wrAddrOk = ({1'b0, i_addr_w} < N_ADDR_EXT);
  assign w_userWe   = w_ready && i_wr && w_wrAddrOk;
  assign w_memWe    = !i_reset && (w_clearWe || w_userWe);
  assign w_memAddr  = w_clearWe ? r_clearCnt : i_addr_w;
  assign w_memData  = w_clearWe ? '0 : i_data;

  // Single write port into the array, shared by the clear sequencer and the core.
  always_ff @(posedge i_clock) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  assign w_rdReqA    = w_ready && i_rd_a;
  assign w_rdReqB    = w_ready && i_rd_b;
  assign w_rdAddrOkA = ({1'b0, i_addr_a} < N_ADDR_EXT);
  assign w_rdAddrOkB = ({1'b0, i_addr_b} < N_ADDR_EXT);

  // Port A read word: out-of-range addresses read as zero; with the bypass
  // enabled a same-cycle write to the same address forwards the new data.
  always_comb begin
    w_rdWordA = '0;
    if (w_rdAddrOkA) begin
      w_rdWordA = r_mem[i_addr_a];
`ifdef BIP_DMEM_WR_BYPASS_EN
      if (w_userWe && (i_addr_w == i_addr_a)) begin
        w_rdWordA = i_data;
      end
`endif
    end
  end

  // Port B read word: same rules as port A, fully independent.
  always_comb begin
    w_rdWordB = '0;
    if (w_rdAddrOkB) begin
      w_rdWordB = r_mem[i_addr_b];
`ifdef BIP_DMEM_WR_BYPASS_EN
      if (w_userWe && (i_addr_w == i_addr_b)) begin
        w_rdWordB = i_data;
      end
`endif
    end
  end

  // First output stage for port A: data only changes when a read completes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_validA1 <= 1'b0;
      r_dataA1  <= '0;
    end else begin
      r_validA1 <= w_rdReqA;
      if (w_rdReqA) begin
        r_dataA1 <= w_rdWordA;
      end
    end
  end

  // First output stage for port B.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_validB1 <= 1'b0;
      r_dataB1  <= '0;
    end else begin
      r_validB1 <= w_rdReqB;
      if (w_rdReqB) begin
        r_dataB1 <= w_rdWordB;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic               r_validA2;
      logic               r_validB2;
      logic [NB_DATA-1:0] r_dataA2;
      logic [NB_DATA-1:0] r_dataB2;

      // Second output stage for port A: valid and data move together.
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          r_validA2 <= 1'b0;
          r_dataA2  <= '0;
        end else begin
          r_validA2 <= r_validA1;
          if (r_validA1) begin
            r_dataA2 <= r_dataA1;
          end
        end
      end

      // Second output stage for port B.
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          r_validB2 <= 1'b0;
          r_dataB2  <= '0;
        end else begin
          r_validB2 <= r_validB1;
          if (r_validB1) begin
            r_dataB2 <= r_dataB1;
          end
        end
      end

      assign o_data_a  = r_dataA2;
      assign o_valid_a = r_validA2;
      assign o_data_b  = r_dataB2;
      assign o_valid_b = r_validB2;
    end else begin : g_lat1
      assign o_data_a  = r_dataA1;
      assign o_valid_a = r_validA1;
      assign o_data_b  = r_dataB1;
      assign o_valid_b = r_validB1;
    end
  endgenerate

endmodule

// File: tb/tb_bip_data_memory_2r1w.sv
// tb_bip_data_memory_2r1w: directed bench driving a latency-1 and a latency-2
// instance of bip_data_memory_2r1w from shared inputs (N_ADDR=16, 5-bit addresses).
// Honours BIP_DMEM_WR_BYPASS_EN when choosing same-cycle read/write expectations.
module tb_bip_data_memory_2r1w;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wr = 1'b0;
  logic [4:0]  i_addr_w = '0;
  logic [15:0] i_data = '0;
  logic        i_rd_a = 1'b0;
  logic [4:0]  i_addr_a = '0;
  logic        i_rd_b = 1'b0;
  logic [4:0]  i_addr_b = '0;

  logic [15:0] dA1, dB1, dA2, dB2;
  logic        vA1, vB1, vA2, vB2;
  logic        busy1, busy2;

  int assertCount = 0;
  int failCount   = 0;

`ifdef BIP_DMEM_WR_BYPASS_EN
  localparam logic [15:0] EXP_A = 16'h1234;
  localparam logic [15:0] EXP_B = 16'h7777;
`else
  localparam logic [15:0] EXP_A = 16'hBEEF;
  localparam logic [15:0] EXP_B = 16'h0000;
`endif

  bip_data_memory_2r1w #(
    .NB_DATA(16), .N_ADDR(16), .LOG2_N_DATA_ADDR(5), .RD_LATENCY(1)
  ) u_lat1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_wr(i_wr), .i_addr_w(i_addr_w), .i_data(i_data),
    .i_rd_a(i_rd_a), .i_addr_a(i_addr_a), .o_data_a(dA1), .o_valid_a(vA1),
    .i_rd_b(i_rd_b), .i_addr_b(i_addr_b), .o_data_b(dB1), .o_valid_b(vB1),
    .o_busy(busy1)
  );

  bip_data_memory_2r1w #(
    .NB_DATA(16), .N_ADDR(16), .LOG2_N_DATA_ADDR(5), .RD_LATENCY(2)
  ) u_lat2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_wr(i_wr), .i_addr_w(i_addr_w), .i_data(i_data),
    .i_rd_a(i_rd_a), .i_addr_a(i_addr_a), .o_data_a(dA2), .o_valid_a(vA2),
    .i_rd_b(i_rd_b), .i_addr_b(i_addr_b), .o_data_b(dB2), .o_valid_b(vB2),
    .o_busy(busy2)
  );

  // Free-running clock, 10 time units per period.
  always #5 i_clock = ~i_clock;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic applyStimulus(input logic wr, input logic [4:0] aw, input logic [15:0] d,
                               input logic ra, input logic [4:0] aa,
                               input logic rb, input logic [4:0] ab);
    i_wr = wr; i_addr_w = aw; i_data = d;
    i_rd_a = ra; i_addr_a = aa;
    i_rd_b = rb; i_addr_b = ab;
    cycle();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic waitReady(output int cycles);
    i_wr = 1'b0; i_rd_a = 1'b0; i_rd_b = 1'b0;
    cycles = 0;
    while (busy1 && cycles < 64) begin
      cycles++;
      cycle();
    end
  endtask

  task automatic test_reset();
    int n;
    i_reset = 1'b1;
    idle();
    assertCount++;
    if ({busy1, vA1, dA1, vB1, dB1} !== {1'b1, 1'b0, 16'h0, 1'b0, 16'h0}) begin
      failCount++;
      $display("[TB] FAIL reset_lat1: got busy=%b vA=%b dA=%h vB=%b dB=%h expected 1 0 0000 0 0000", busy1, vA1, dA1, vB1, dB1);
    end
    assertCount++;
    if ({busy2, vA2, dA2, vB2, dB2} !== {1'b1, 1'b0, 16'h0, 1'b0, 16'h0}) begin
      failCount++;
      $display("[TB] FAIL reset_lat2: got busy=%b vA=%b dA=%h vB=%b dB=%h expected 1 0 0000 0 0000", busy2, vA2, dA2, vB2, dB2);
    end
    i_reset = 1'b0;
    waitReady(n);
    assertCount++;
    if (n !== 16 || busy2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_busy_cycles: got %0d (busy2=%b) expected 16 (busy2=0)", n, busy2);
    end
    for (int i = 0; i <= 16; i++) begin
      applyStimulus(1'b0, 5'd0, 16'h0, (i < 16), 5'(i), (i < 16), 5'(15 - i));
      assertCount++;
      if (i < 16) begin
        if ({vA1, dA1, vB1, dB1} !== {1'b1, 16'h0, 1'b1, 16'h0}) begin
          failCount++;
          $display("[TB] FAIL reset_read_lat1[%0d]: got vA=%b dA=%h vB=%b dB=%h expected 1 0000 1 0000", i, vA1, dA1, vB1, dB1);
        end
      end else if ({vA1, vB1} !== 2'b00) begin
        failCount++;
        $display("[TB] FAIL reset_read_lat1_end: got vA=%b vB=%b expected 0 0", vA1, vB1);
      end
      assertCount++;
      if (i >= 1) begin
        if ({vA2, dA2, vB2, dB2} !== {1'b1, 16'h0, 1'b1, 16'h0}) begin
          failCount++;
          $display("[TB] FAIL reset_read_lat2[%0d]: got vA=%b dA=%h vB=%b dB=%h expected 1 0000 1 0000", i, vA2, dA2, vB2, dB2);
        end
      end else if ({vA2, vB2} !== 2'b00) begin
        failCount++;
        $display("[TB] FAIL reset_read_lat2_early: got vA=%b vB=%b expected 0 0", vA2, vB2);
      end
    end
  endtask

  task automatic test_write_read_both();
    applyStimulus(1'b1, 5'd5, 16'hBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    assertCount++;
    if ({vA1, dA1, vB1, dB1, vA2, vB2} !== {1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL both_lat1: got vA=%b dA=%h vB=%b dB=%h v2=%b%b expected 1 beef 1 beef 00", vA1, dA1, vB1, dB1, vA2, vB2);
    end
    idle();
    assertCount++;
    if ({vA2, dA2, vB2, dB2} !== {1'b1, 16'hBEEF, 1'b1, 16'hBEEF}) begin
      failCount++;
      $display("[TB] FAIL both_lat2: got vA=%b dA=%h vB=%b dB=%h expected 1 beef 1 beef", vA2, dA2, vB2, dB2);
    end
    assertCount++;
    if ({vA1, dA1, vB1, dB1} !== {1'b0, 16'hBEEF, 1'b0, 16'hBEEF}) begin
      failCount++;
      $display("[TB] FAIL both_lat1_hold: got vA=%b dA=%h vB=%b dB=%h expected 0 beef 0 beef", vA1, dA1, vB1, dB1);
    end
    idle();
    assertCount++;
    if ({vA2, dA2, vB2, dB2} !== {1'b0, 16'hBEEF, 1'b0, 16'hBEEF}) begin
      failCount++;
      $display("[TB] FAIL both_lat2_hold: got vA=%b dA=%h vB=%b dB=%h expected 0 beef 0 beef", vA2, dA2, vB2, dB2);
    end
  endtask

  task automatic test_bypass();
    applyStimulus(1'b1, 5'd3, 16'hBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd3, 16'h1234, 1'b1, 5'd3, 1'b0, 5'd0);
    assertCount++;
    if ({vA1, dA1} !== {1'b1, EXP_A}) begin
      failCount++;
      $display("[TB] FAIL bypass_a_lat1: got vA=%b dA=%h expected 1 %h", vA1, dA1, EXP_A);
    end
    applyStimulus(1'b1, 5'd4, 16'h7777, 1'b0, 5'd0, 1'b1, 5'd4);
    assertCount++;
    if ({vA1, vB1, dB1} !== {1'b0, 1'b1, EXP_B}) begin
      failCount++;
      $display("[TB] FAIL bypass_b_lat1: got vA=%b vB=%b dB=%h expected 0 1 %h", vA1, vB1, dB1, EXP_B);
    end
    assertCount++;
    if ({vA2, dA2} !== {1'b1, EXP_A}) begin
      failCount++;
      $display("[TB] FAIL bypass_a_lat2: got vA=%b dA=%h expected 1 %h", vA2, dA2, EXP_A);
    end
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 1'b1, 5'd4);
    assertCount++;
    if ({vB2, dB2} !== {1'b1, EXP_B}) begin
      failCount++;
      $display("[TB] FAIL bypass_b_lat2: got vB=%b dB=%h expected 1 %h", vB2, dB2, EXP_B);
    end
    assertCount++;
    if ({vA1, dA1, vB1, dB1} !== {1'b1, 16'h1234, 1'b1, 16'h7777}) begin
      failCount++;
      $display("[TB] FAIL bypass_after_lat1: got vA=%b dA=%h vB=%b dB=%h expected 1 1234 1 7777", vA1, dA1, vB1, dB1);
    end
    idle();
    assertCount++;
    if ({vA2, dA2, vB2, dB2} !== {1'b1, 16'h1234, 1'b1, 16'h7777}) begin
      failCount++;
      $display("[TB] FAIL bypass_after_lat2: got vA=%b dA=%h vB=%b dB=%h expected 1 1234 1 7777", vA2, dA2, vB2, dB2);
    end
  endtask

  task automatic test_out_of_range();
    applyStimulus(1'b1, 5'd20, 16'h9999, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd20, 1'b1, 5'd5);
    assertCount++;
    if ({vA1, dA1, vB1, dB1} !== {1'b1, 16'h0, 1'b1, 16'hBEEF}) begin
      failCount++;
      $display("[TB] FAIL oor_lat1: got vA=%b dA=%h vB=%b dB=%h expected 1 0000 1 beef", vA1, dA1, vB1, dB1);
    end
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd4, 1'b0, 5'd0);
    assertCount++;
    if ({vA1, dA1} !== {1'b1, 16'h7777}) begin
      failCount++;
      $display("[TB] FAIL oor_neighbour: got vA=%b dA=%h expected 1 7777", vA1, dA1);
    end
    assertCount++;
    if ({vA2, dA2, vB2, dB2} !== {1'b1, 16'h0, 1'b1, 16'hBEEF}) begin
      failCount++;
      $display("[TB] FAIL oor_lat2: got vA=%b dA=%h vB=%b dB=%h expected 1 0000 1 beef", vA2, dA2, vB2, dB2);
    end
  endtask

  task automatic test_reset_midclear();
    int n;
    applyStimulus(1'b1, 5'd2, 16'hAAAA, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd2, 1'b0, 5'd0);
    assertCount++;
    if ({vA1, dA1} !== {1'b1, 16'hAAAA}) begin
      failCount++;
      $display("[TB] FAIL midclear_preload: got vA=%b dA=%h expected 1 aaaa", vA1, dA1);
    end
    i_reset = 1'b1;
    idle();
    i_reset = 1'b0;
    for (int i = 0; i < 7; i++) idle();
    assertCount++;
    if ({busy1, busy2} !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL midclear_busy_at7: got %b%b expected 11", busy1, busy2);
    end
    i_reset = 1'b1;
    idle();
    i_reset = 1'b0;
    waitReady(n);
    assertCount++;
    if (n !== 16) begin
      failCount++;
      $display("[TB] FAIL midclear_busy_cycles: got %0d expected 16", n);
    end
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd2, 1'b1, 5'd2);
    assertCount++;
    if ({vA1, dA1, vB1, dB1} !== {1'b1, 16'h0, 1'b1, 16'h0}) begin
      failCount++;
      $display("[TB] FAIL midclear_read_lat1: got vA=%b dA=%h vB=%b dB=%h expected 1 0000 1 0000", vA1, dA1, vB1, dB1);
    end
    idle();
    assertCount++;
    if ({vA2, dA2, vB2, dB2} !== {1'b1, 16'h0, 1'b1, 16'h0}) begin
      failCount++;
      $display("[TB] FAIL midclear_read_lat2: got vA=%b dA=%h vB=%b dB=%h expected 1 0000 1 0000", vA2, dA2, vB2, dB2);
    end
  endtask

  task automatic test_clear_requests();
    int n;
    i_reset = 1'b1;
    idle();
    i_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5'd0, 16'h5555, 1'b1, 5'd0, 1'b1, 5'd1);
      assertCount++;
      if ({vA1, vB1, vA2, vB2, dA1, dA2, busy1} !== {4'b0000, 16'h0, 16'h0, 1'b1}) begin
        failCount++;
        $display("[TB] FAIL clear_ignore[%0d]: got v=%b%b%b%b dA1=%h dA2=%h busy=%b expected 0000 0000 0000 1", i, vA1, vB1, vA2, vB2, dA1, dA2, busy1);
      end
    end
    waitReady(n);
    assertCount++;
    if (n !== 11) begin
      failCount++;
      $display("[TB] FAIL clear_remaining_cycles: got %0d expected 11", n);
    end
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd0, 1'b0, 5'd0);
    assertCount++;
    if ({vA1, dA1} !== {1'b1, 16'h0}) begin
      failCount++;
      $display("[TB] FAIL clear_addr0_lat1: got vA=%b dA=%h expected 1 0000", vA1, dA1);
    end
    idle();
    assertCount++;
    if ({vA2, dA2} !== {1'b1, 16'h0}) begin
      failCount++;
      $display("[TB] FAIL clear_addr0_lat2: got vA=%b dA=%h expected 1 0000", vA2, dA2);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 5'(i), 16'(i), 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 1'b1, 5'd5);
    assertCount++;
    if ({vB1, dB1} !== {1'b1, 16'h0005}) begin
      failCount++;
      $display("[TB] FAIL stream_b_setup: got vB=%b dB=%h expected 1 0005", vB1, dB1);
    end
    for (int i = 0; i <= 8; i++) begin
      applyStimulus(1'b0, 5'd0, 16'h0, (i < 8), 5'(i), 1'b0, 5'd0);
      assertCount++;
      if (i < 8) begin
        if ({vA1, dA1, vB1, dB1} !== {1'b1, 16'(i), 1'b0, 16'h0005}) begin
          failCount++;
          $display("[TB] FAIL stream_lat1[%0d]: got vA=%b dA=%h vB=%b dB=%h expected 1 %h 0 0005", i, vA1, dA1, vB1, dB1, 16'(i));
        end
      end else if ({vA1, dA1} !== {1'b0, 16'h0007}) begin
        failCount++;
        $display("[TB] FAIL stream_lat1_end: got vA=%b dA=%h expected 0 0007", vA1, dA1);
      end
      assertCount++;
      if (i == 0) begin
        if ({vA2, vB2, dB2} !== {1'b0, 1'b1, 16'h0005}) begin
          failCount++;
          $display("[TB] FAIL stream_lat2_first: got vA=%b vB=%b dB=%h expected 0 1 0005", vA2, vB2, dB2);
        end
      end else if ({vA2, dA2, vB2, dB2} !== {1'b1, 16'(i - 1), 1'b0, 16'h0005}) begin
        failCount++;
        $display("[TB] FAIL stream_lat2[%0d]: got vA=%b dA=%h vB=%b dB=%h expected 1 %h 0 0005", i, vA2, dA2, vB2, dB2, 16'(i - 1));
      end
    end
  endtask

  // Test sequence: each task drives its scenario and checks its own results.
  initial begin
    test_reset();
    test_write_read_both();
    test_bypass();
    test_out_of_range();
    test_reset_midclear();
    test_clear_requests();
    test_back_to_back();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bip_data_memory_2r1w.md
Name: bip_data_memory_2r1w

Overview:
Parametrised data memory for the BIP datapath with one write port and two independent read ports (A, B), registered outputs with selectable read latency, and per-port read-valid flags. On reset, a built-in clear sequencer zeroes every word, so the memory never exposes stale contents. The block replaces the single-port data memory where the core needs two operands per cycle, or debug/UART readback concurrent with core access.

Parameters:
NB_DATA, 16, data word width in bits
N_ADDR, 1024, number of words (1 <= N_ADDR <= 2**LOG2_N_DATA_ADDR)
LOG2_N_DATA_ADDR, 10, address width in bits
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2

Ports:
i_clock  in  1  single clock, all logic on rising edge
i_reset  in  1  synchronous reset, active-high
i_wr  in  1  write enable
i_addr_w  in  LOG2_N_DATA_ADDR  write address
i_data  in  NB_DATA  write data
i_rd_a  in  1  port A read enable
i_addr_a  in  LOG2_N_DATA_ADDR  port A read address
o_data_a  out  NB_DATA  port A read data
o_valid_a  out  1  port A read-data valid pulse
i_rd_b  in  1  port B read enable
i_addr_b  in  LOG2_N_DATA_ADDR  port B read address
o_data_b  out  NB_DATA  port B read data
o_valid_b  out  1  port B read-data valid pulse
o_busy  out  1  clear sequence in progress; all requests ignored

Behaviour:
- Reset (i_reset=1 at a rising edge): o_data_a=o_data_b=0, o_valid_a=o_valid_b=0, o_busy=1, clear counter=0, read pipeline flushed, FSM -> CLEAR.
- FSM states: CLEAR, READY.
- CLEAR: each cycle, write 0 to mem[counter] and increment counter. After writing word N_ADDR-1, go to READY and drop o_busy to 0 on the next edge. A clear takes exactly N_ADDR cycles after reset deasserts.
- While in CLEAR, i_wr, i_rd_a and i_rd_b are ignored: no writes, no valids, outputs hold 0.
- Reset asserted mid-CLEAR or in READY restarts CLEAR from address 0.
- READY write: mem[i_addr_w] <= i_data at the edge when i_wr=1.
- READY read, port X: i_rd_x=1 sampled at edge N -> o_data_x updated and o_valid_x=1 for one cycle after edge N+RD_LATENCY-1. With RD_LATENCY=1, data appears in the cycle after the request.
- Back-to-back reads stream at one per cycle on each port.
- o_data_x holds its last read value when no read completes. o_valid_x is 0 in those cycles.
- Ports A and B are fully independent. The same address on both ports returns identical data.
- Address >= N_ADDR: writes are dropped; reads return 0 with valid asserted.
- Read of address W while i_wr=1 to W in the same cycle: result governed by the optional feature below.
- RD_LATENCY=2 adds one output register stage per port; valid and data stay aligned.

Optional Feature:
Macro BIP_DMEM_WR_BYPASS_EN.
- Defined: write-first. A same-cycle read of the address being written returns the new i_data, on either port.
- Undefined: read-first. Such a read returns the old contents; the new value is visible from the next read onward.

Test Plan:
- Reset with N_ADDR=16: o_busy=1 for exactly 16 cycles after reset release. Reads of all 16 addresses then return 0x0000 with o_valid pulses.
- In READY, write 0xBEEF to addr 5, then i_rd_a at addr 5 and i_rd_b at addr 5 in the same cycle -> both ports return 0xBEEF with valid after RD_LATENCY cycles (check RD_LATENCY=1 and 2).
- Same-cycle write 0x1234 to addr 3 (old value 0xBEEF) plus read A of addr 3 -> 0x1234 with BIP_DMEM_WR_BYPASS_EN defined, 0xBEEF without it.
- Reset asserted at clear-counter 7, after addr 2 was previously written 0xAAAA -> o_busy stays high for a full N_ADDR cycles from release, and addr 2 then reads 0.
- Requests during CLEAR (write 0x5555 to addr 0, read A addr 0) -> no o_valid_a. After READY, addr 0 reads 0x0000.
- Streaming reads of A on addrs 0..7 (preloaded with i) with B idle -> o_data_a = 0..7 on consecutive cycles, o_valid_a high for 8 cycles, o_valid_b stays 0, o_data_b unchanged.
